// File: rtl/crc_sched_pkg.sv
// crc_sched_pkg: shared constants, FSM states and job record for the CRC job scheduler
package crc_sched_pkg;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 11;
    localparam int CRC_W  = 16;
    localparam int DATA_W = 8;
    localparam int ID_W   = 3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_REPORT} state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [CRC_W-1:0]  target;
    } job_t;

    // Lengths beyond the memory depth would re-read bytes, so they are capped at one full pass.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(1 << ADDR_W)) ? LEN_W'(1 << ADDR_W) : l;
    endfunction
endpackage

// File: rtl/crc_job_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at/after the pointer
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   advance    : move pointer past the current winner
//   gnt, idx   : one-hot winner and its index
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr_q) + i) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr_q) + i) % N);
                gnt[(int'(ptr_q) + i) % N] = 1'b1;
            end
        end
        ptr_d = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else if (advance) ptr_q <= ptr_d;
endmodule

// File: rtl/crc_job_scheduler.sv
// crc_job_scheduler: shares one byte-serial CRC engine and its memory among NUM_REQ clients
//   clk50m, rst_n                  : clock, async active-low reset
//   req/req_addr/req_len/req_target: per-client job requests (slice i = client i)
//   gnt, busy                      : one-hot accept pulse, job in progress
//   mem_addr, mem_data             : sync memory read port (data one cycle later)
//   crc_clr, crc_en, crc_byte      : engine control, crc_val engine register
//   done, done_id, done_crc, done_ok: result pulse and held result fields
module crc_job_scheduler
    import crc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk50m,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    input  logic [NUM_REQ*CRC_W-1:0]   req_target,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       crc_clr,
    output logic                       crc_en,
    output logic [DATA_W-1:0]          crc_byte,
    input  logic [CRC_W-1:0]           crc_val,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic [CRC_W-1:0]           done_crc,
    output logic                       done_ok
);
    localparam int IW = $clog2(NUM_REQ);

    state_e            state_q, state_d;
    job_t              job_q, job_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [CRC_W-1:0]  done_crc_q, done_crc_d;
    logic              done_ok_q, done_ok_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic [NUM_REQ-1:0] a_gnt;
    logic [IW-1:0]     a_idx;
    logic              advance;

    assign advance = (state_q == S_IDLE) && |req;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk50m),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .gnt     (a_gnt),
        .idx     (a_idx)
    );

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        done_crc_d = done_crc_q;
        done_ok_d  = done_ok_q;
        done_id_d  = done_id_q;
        case (state_q)
            S_IDLE: if (|req) begin
                job_d.id     = ID_W'(a_idx);
                job_d.addr   = req_addr[a_idx*ADDR_W +: ADDR_W];
                job_d.len    = clamp_len(req_len[a_idx*LEN_W +: LEN_W]);
                job_d.target = req_target[a_idx*CRC_W +: CRC_W];
                addr_d       = req_addr[a_idx*ADDR_W +: ADDR_W];
                cnt_d        = clamp_len(req_len[a_idx*LEN_W +: LEN_W]);
                state_d      = S_LOAD;
            end
            S_LOAD: begin
                addr_d  = addr_q + 1'b1;
                state_d = (cnt_q == '0) ? S_FLUSH : S_STREAM;
            end
            // cnt_q counts bytes still to be consumed; the read one ahead past the end is harmless.
            S_STREAM: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == LEN_W'(1)) ? S_FLUSH : S_STREAM;
            end
            S_FLUSH: begin
                done_crc_d = crc_val;
                done_ok_d  = (crc_val == job_q.target);
                done_id_d  = job_q.id[IW-1:0];
                state_d    = S_REPORT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n)
        if (!rst_n) begin
            state_q    <= S_IDLE;
            job_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            done_crc_q <= '0;
            done_ok_q  <= 1'b0;
            done_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            job_q      <= job_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            done_crc_q <= done_crc_d;
            done_ok_q  <= done_ok_d;
            done_id_q  <= done_id_d;
        end

    // gnt is combinational from req, so it is gated to stay 0 while reset is asserted.
    assign gnt      = (state_q == S_IDLE && rst_n) ? a_gnt : '0;
    assign busy     = state_q != S_IDLE;
    assign mem_addr = addr_q;
    assign crc_clr  = state_q == S_LOAD;
    assign crc_en   = state_q == S_STREAM;
    assign crc_byte = crc_en ? mem_data : '0;
    assign done     = state_q == S_REPORT;
    assign done_id  = done_id_q;
    assign done_crc = done_crc_q;
    assign done_ok  = done_ok_q;
endmodule

// File: tb/tb_crc_job_scheduler.sv
// tb_crc_job_scheduler: directed bench with behavioural memory and CRC-16/CCITT engine
module tb_crc_job_scheduler;
    logic        clk50m = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [39:0] req_addr;
    logic [43:0] req_len;
    logic [63:0] req_target;
    logic [3:0]  gnt;
    logic        busy;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        crc_clr, crc_en;
    logic [7:0]  crc_byte;
    logic [15:0] crc_val;
    logic        done;
    logic [1:0]  done_id;
    logic [15:0] done_crc;
    logic        done_ok;

    logic [7:0]  mem [1024];
    int          n_chk = 0;
    int          n_pass = 0;

    crc_job_scheduler #(.NUM_REQ(4)) dut (
        .clk50m(clk50m), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_target(req_target), .gnt(gnt), .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data),
        .crc_clr(crc_clr), .crc_en(crc_en), .crc_byte(crc_byte), .crc_val(crc_val), .done(done),
        .done_id(done_id), .done_crc(done_crc), .done_ok(done_ok)
    );

    always #10 clk50m = ~clk50m;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_of(input int base, input int len);
        logic [15:0] c;
        logic [9:0]  a;
        c = 16'hFFFF;
        for (int k = 0; k < len; k++) begin
            a = 10'(base + k);
            c = crc_step(c, mem[a]);
        end
        return c;
    endfunction

    always @(posedge clk50m) mem_data <= mem[mem_addr];

    always @(posedge clk50m or negedge rst_n)
        if (!rst_n) crc_val <= 16'hFFFF;
        else if (crc_clr) crc_val <= 16'hFFFF;
        else if (crc_en) crc_val <= crc_step(crc_val, crc_byte);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_job(input string tag, input int id, input int base, input int len,
                          input logic [15:0] tgt);
        int leff, bad_addr, en_cnt, bad_en, bad_clr, done_at, done_n;
        logic [15:0] exp_crc;
        leff = (len > 1024) ? 1024 : len;
        exp_crc = crc_of(base, leff);
        bad_addr = 0; en_cnt = 0; bad_en = 0; bad_clr = 0; done_at = -1; done_n = 0;
        @(negedge clk50m);
        req_addr[id*10 +: 10]   = 10'(base);
        req_len[id*11 +: 11]    = 11'(len);
        req_target[id*16 +: 16] = tgt;
        req[id] = 1'b1;
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << id));
        for (int t = 1; t <= leff + 5; t++) begin
            @(negedge clk50m);
            if (t == 1) req[id] = 1'b0;
            #1;
            if (t <= leff && mem_addr != 10'(base + t - 1)) bad_addr++;
            if (crc_en) begin
                en_cnt++;
                if (t < 2 || t > leff + 1 || crc_clr) bad_en++;
            end
            if (crc_clr != (t == 1)) bad_clr++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = t;
            end
        end
        chk({tag, "_addr_errs"}, 32'(bad_addr), 0);
        chk({tag, "_en_cnt"}, 32'(en_cnt), 32'(leff));
        chk({tag, "_en_timing_errs"}, 32'(bad_en), 0);
        chk({tag, "_clr_errs"}, 32'(bad_clr), 0);
        chk({tag, "_done_lat"}, 32'(done_at), 32'(leff + 3));
        chk({tag, "_done_pulses"}, 32'(done_n), 1);
        chk({tag, "_done_id"}, 32'(done_id), 32'(id));
        chk({tag, "_done_crc"}, 32'(done_crc), 32'(exp_crc));
        chk({tag, "_done_ok"}, 32'(done_ok), 32'(exp_crc == tgt));
    endtask

    initial begin
        int seq [5];
        int n, done_n;
        seq = '{0, 1, 2, 0, 2};
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
        for (int i = 0; i < 9; i++) mem[100 + i] = 8'(8'h31 + i);
        rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0; req_target = '0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_clr_en", 32'({crc_clr, crc_en}), 0);
        chk("rst_done", 32'({done, done_ok, done_id, done_crc}), 0);
        chk("rst_gnt", 32'(gnt), 0);
        repeat (2) @(negedge clk50m);
        rst_n = 1'b1;

        // Arbitration: all three held, then clients 0 and 2, pointer starting at 0.
        @(negedge clk50m);
        req = 4'b0111;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                req = 4'b0101;
                #1;
            end
            n = 0;
            while (gnt == '0 && n < 40) begin
                @(negedge clk50m);
                #1;
                n++;
            end
            chk($sformatf("arb%0d", k), 32'(gnt), 32'(1 << seq[k]));
            @(negedge clk50m);
            req[seq[k]] = 1'b0;
        end
        repeat (6) @(negedge clk50m);

        do_job("t1", 0, 0, 4, crc_of(0, 4));
        do_job("t2", 1, 1022, 4, 16'h0000);
        do_job("t4", 3, 5, 0, 16'h1234);
        chk("t4_init_crc", 32'(done_crc), 32'h0000FFFF);
        do_job("t5", 2, 200, 6, 16'd32043);
        chk("t5_ok_low", 32'(done_ok), 0);
        do_job("ascii", 3, 100, 9, 16'h29B1);
        chk("ascii_crc", 32'(done_crc), 32'h000029B1);
        do_job("clamp", 1, 0, 2000, 16'h0000);

        // Reset in the middle of a streaming job.
        @(negedge clk50m);
        req_addr[9:0] = 10'd0; req_len[10:0] = 11'd8; req[0] = 1'b1;
        @(negedge clk50m);
        req[0] = 1'b0;
        repeat (2) @(negedge clk50m);
        #1;
        chk("t6_pre_en", 32'(crc_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ctrl", 32'({crc_clr, crc_en, crc_byte}), 0);
        chk("t6_mem_addr", 32'(mem_addr), 0);
        chk("t6_result", 32'({done, done_ok, done_id, done_crc}), 0);
        repeat (2) @(negedge clk50m);
        rst_n = 1'b1;
        done_n = 0;
        repeat (14) begin
            @(negedge clk50m);
            #1;
            if (done) done_n++;
        end
        chk("t6_no_done", 32'(done_n), 0);
        do_job("t6_rerun", 0, 0, 4, crc_of(0, 4));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
